// File: rtl/iterative_normalizer_pkg.sv
// -----------------------------------------------------------------------------
// iterative_normalizer_pkg
// Shared definitions for the iterative normalizer:
//   - norm_state_e : controller states (idle / shifting)
//   - DIR_LEFT     : normalize toward the MSB (shift left)
//   - DIR_RIGHT    : normalize toward the LSB (logical shift right)
//   - DEFAULT_WIDTH: default operand width
// -----------------------------------------------------------------------------
package iterative_normalizer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        StIdle,
        StShift
    } norm_state_e;

endpackage

// File: rtl/iterative_normalizer.sv
// -----------------------------------------------------------------------------
// iterative_normalizer
// Shifts an operand one bit per cycle until its leading one (dir=0, toward
// the MSB) or trailing one (dir=1, toward the LSB) sits at the end of the
// word, then reports the normalized word and the number of shifts applied.
// Shifting `out` back by `shamt` in the opposite direction recovers `in`.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   in     in   operand, captured on an accepted start
//   dir    in   0 = normalize toward MSB, 1 = normalize toward LSB
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse, result valid
//   out    out  normalized word, held until the next completion
//   shamt  out  shifts applied, held until the next completion
//   zero   out  operand was all zeros, held until the next completion
// -----------------------------------------------------------------------------
module iterative_normalizer
    import iterative_normalizer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [SHW-1:0]   shamt,
    output logic             zero
);

    norm_state_e      state;
    logic [WIDTH-1:0] work;
    logic             dir_q;
    logic [SHW-1:0]   count;

    logic target_bit;
    logic work_zero;

    // Bit that must become 1 for the word to count as normalized.
    assign target_bit = (dir_q == DIR_RIGHT) ? work[0] : work[WIDTH-1];
    assign work_zero  = (work == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            work  <= '0;
            dir_q <= DIR_LEFT;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            shamt <= '0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        work  <= in;
                        dir_q <= dir;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    // An all-zero word can never normalize; finish at once.
                    if (target_bit || work_zero) begin
                        out   <= work;
                        shamt <= count;
                        zero  <= work_zero;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        if (dir_q == DIR_RIGHT) begin
                            work <= work >> 1;
                        end else begin
                            work <= work << 1;
                        end
                        // At most WIDTH-1 shifts for a nonzero word, so no wrap.
                        count <= count + SHW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_normalizer.sv
module tb_iterative_normalizer;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   in_s;
    logic           dir_s;
    logic           busy;
    logic           done;
    logic [W-1:0]   out_s;
    logic [SHW-1:0] shamt;
    logic           zero;

    int total = 0;
    int bad   = 0;

    iterative_normalizer #(
        .WIDTH(W),
        .SHW  (SHW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .in   (in_s),
        .dir  (dir_s),
        .busy (busy),
        .done (done),
        .out  (out_s),
        .shamt(shamt),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift count is the leading-zero count (dir=0) or the
    // trailing-zero count (dir=1), derived from logarithms of the value.
    function automatic void model(input int v, input bit d, output int k, output int o,
                                  output bit z);
        if (v == 0) begin
            k = 0;
            o = 0;
            z = 1'b1;
        end else begin
            z = 1'b0;
            if (d == 1'b0) begin
                k = W - $clog2(v + 1);
                o = (v * (1 << k)) % (1 << W);
            end else begin
                k = $clog2(v & -v);
                o = v / (1 << k);
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run_op(input logic [W-1:0] v, input bit d, input bit poke);
        int  k, o, cyc;
        bit  z, seen;
        model(int'(v), d, k, o, z);
        check_eq("idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1;
        in_s  = v;
        dir_s = d;
        @(posedge clk);
        @(negedge clk);
        check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
        if (poke) begin
            in_s  = ~v;
            dir_s = ~d;
        end else begin
            start = 1'b0;
        end
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                cyc  = c;
                break;
            end
        end
        check_eq("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check_eq("latency", cyc, k + 1);
            check_eq("out", {24'd0, out_s}, o);
            check_eq("shamt", {29'd0, shamt}, k);
            check_eq("zero", {31'd0, zero}, {31'd0, z});
            check_eq("busy_in_done", {31'd0, busy}, 32'd0);
            if (!z) begin
                if (d == 1'b0) check_eq("inverse_l", {24'd0, out_s >> shamt}, {24'd0, v});
                else           check_eq("inverse_r", {24'd0, W'(out_s << shamt)}, {24'd0, v});
            end
        end
    endtask

    task automatic idle_gap(input int n);
        logic [W-1:0] o_hold;
        o_hold = out_s;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("done_drops", {31'd0, done}, 32'd0);
            check_eq("out_held", {24'd0, out_s}, {24'd0, o_hold});
        end
    endtask

    initial begin
        int          k, o, pend_k, pend_o;
        bit          z, pend, pend_z, seen;
        int          dones;
        logic [W-1:0] rv;

        rst_n = 1'b0;
        start = 1'b0;
        in_s  = '0;
        dir_s = 1'b0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_out", {24'd0, out_s}, 32'd0);
        check_eq("rst_shamt", {29'd0, shamt}, 32'd0);
        check_eq("rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(8'b0010_1011, 1'b0, 1'b0);
        idle_gap(1);
        run_op(8'b1011_1000, 1'b1, 1'b0);
        run_op(8'b1000_0000, 1'b0, 1'b0);
        run_op(8'b0000_0001, 1'b0, 1'b1);
        run_op(8'b0000_0000, 1'b0, 1'b0);
        run_op(8'b0000_0000, 1'b1, 1'b0);
        run_op(8'b0100_0000, 1'b0, 1'b0);
        run_op(8'b0000_0001, 1'b1, 1'b1);
        run_op(8'b1000_0000, 1'b1, 1'b0);
        idle_gap(2);

        // Random operations with random gaps and busy-time start pokes.
        for (int n = 0; n < 40; n++) begin
            rv = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rv = W'(rv << $urandom_range(0, 7));
            run_op(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_gap(int'($urandom_range(0, 2)));
        end

        // start held high continuously; operands change every cycle.
        @(negedge clk);
        pend  = 1'b0;
        dones = 0;
        for (int c = 0; c < 200 && dones < 12; c++) begin
            if (done) begin
                dones++;
                check_eq("cont_busy_done", {31'd0, busy}, 32'd0);
                check_eq("cont_pending", {31'd0, pend}, 32'd1);
                check_eq("cont_out", {24'd0, out_s}, pend_o);
                check_eq("cont_shamt", {29'd0, shamt}, pend_k);
                check_eq("cont_zero", {31'd0, zero}, {31'd0, pend_z});
                pend = 1'b0;
            end
            rv    = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
            dir_s = 1'($urandom_range(0, 1));
            in_s  = rv;
            start = 1'b1;
            if (!busy) begin
                model(int'(rv), dir_s, k, o, z);
                pend_k = k;
                pend_o = o;
                pend_z = z;
                pend   = 1'b1;
            end
            @(negedge clk);
        end
        check_eq("cont_dones", dones, 12);
        start = 1'b0;
        for (int c = 0; c < W + 4 && busy; c++) @(negedge clk);
        @(negedge clk);
        check_eq("cont_drained", {31'd0, busy}, 32'd0);

        // Leave known non-reset outputs, then reset mid-operation.
        run_op(8'b0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        in_s  = 8'b0000_0001;
        dir_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_out", {24'd0, out_s}, 32'd0);
        check_eq("mid_rst_shamt", {29'd0, shamt}, 32'd0);
        check_eq("mid_rst_zero", {31'd0, zero}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq("no_done_after_rst", {31'd0, seen}, 32'd0);
        run_op(8'b0001_0110, 1'b0, 1'b0);
        run_op(8'b0001_0110, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iterative_normalizer.md
Name: iterative_normalizer

Overview:
Sequential inverse of the combinational barrel shifter. Given a word, it shifts one bit per cycle until the leading one reaches the selected end, then reports the normalized word and the shift amount. Applying the barrel shifter to `out` by `shamt` in the opposite direction recovers `in`. Used ahead of shift-based datapaths that need leading-zero/trailing-zero counts; start/done handshake.

Parameters:
WIDTH, 8, data width in bits (>= 2)
SHW, $clog2(WIDTH) (=3), width of shift-amount output

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while idle
in  input  WIDTH  operand, captured on accepted start
dir  input  1  captured with start; 0 = normalize toward MSB (shift left), 1 = normalize toward LSB (logical shift right)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result valid
out  output  WIDTH  normalized word, held until next completion
shamt  output  SHW  number of 1-bit shifts applied, held until next completion
zero  output  1  operand was all zeros, held until next completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, out=0, shamt=0, zero=0; internal working register and counter cleared.
- States: IDLE, SHIFT.
- IDLE: on an edge with start=1, load the working register with `in`, latch `dir`, clear the count, set busy=1, and go to SHIFT. With start=0, stay in IDLE; done returns to 0.
- SHIFT, each edge: target bit is reg[WIDTH-1] when dir=0 and reg[0] when dir=1.
  - If the target bit is 1 or reg==0: out<=reg, shamt<=count, zero<=(reg==0), done<=1 for one cycle, busy<=0, go to IDLE.
  - Otherwise shift reg by 1 toward the target, zero-filling the vacated bit, and increment count.
- Latency: with k = required shifts, done is high in the cycle after edge E0+k+1, where E0 is the start-accept edge. Max k = WIDTH-1 (nonzero input), so worst case is WIDTH cycles. The count never wraps.
- Zero input: completes on the first SHIFT edge with zero=1, out=0, shamt=0.
- start while busy: ignored. No queueing; in and dir are not re-sampled.
- start in the cycle done is high: accepted, since the state is already IDLE. done drops the next cycle.
- out, shamt and zero change only on completion or reset. They are not cleared on a new start.
- Reset mid-operation: aborts immediately to the reset values. No done pulse.
- Arithmetic: count is SHW bits, unsigned. Shifts are logical only, with no sign extension.

Decomposition:
- Shared package: state enum (IDLE, SHIFT), DIR_LEFT=1'b0 / DIR_RIGHT=1'b1 constants, default WIDTH.
- No sub-module is natural: a single-bit shift step is one line. The block stays flat (one state register, one working register, one counter, output registers).

Test Plan:
- Normalize left: in=00101011, dir=0, pulse start -> done after 3 cycles, out=10101100, shamt=2, zero=0. Feeding out and shamt to barrel_shifter with dir=0 (right shift) gives 00101011.
- Normalize right: in=10111000, dir=1 -> done after 4 cycles, out=00010111, shamt=3.
- Bounds: in=10000000, dir=0 -> done after 1 cycle, shamt=0, out unchanged. in=00000001, dir=0 -> done after 8 cycles, out=10000000, shamt=7.
- Zero: in=00000000, either dir -> done after 1 cycle, zero=1, out=0, shamt=0. Next op in=01000000, dir=0 -> zero=0, shamt=1.
- Handshake:
  - start held high continuously with changing in: operands are captured only at accept edges, and busy is never high in a done cycle.
  - start during busy is ignored.
  - back-to-back start in the done cycle is accepted.
- Reset mid-op: start in=00000001, dir=0, assert rst_n=0 at cycle 3 -> all outputs 0 asynchronously, no done pulse. After release, a new op completes normally.
